// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: 4-digit seven-segment scan scheduler with blanking gap,
// tear-free frame-wrap commit of the displayed value and leading-zero blanking.
module seg7_scan_controller #(
   parameter int PRESCALE     = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        load,
   input  logic [15:0] value_in,
   input  logic [3:0]  dot_in,
   input  logic        lzb_en,
   output logic [1:0]  mux_sel,
   output logic [15:0] disp_value,
   output logic [3:0]  anode_n,
   output logic        dot_n,
   output logic        frame_done
);
   localparam int CW = $clog2(PRESCALE);
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] BLK  = CW'(BLANK_CYCLES);

   typedef enum logic {BLANK, ON} state_t;

   state_t        state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [1:0]    sel_nx;
   logic          slot_end, wrap, lit;
   logic [15:0]   pend, disp_nx;
   logic [3:0]    pend_dot, cdot, cdot_nx, lz_mask;
   logic          pend_valid;

   // Outputs register the next-state view so they stay aligned with cnt/mux_sel.
   always_comb begin
      slot_end = enable && cnt == LAST;
      wrap     = slot_end && mux_sel == 2'd3;
      cnt_nx   = (!enable || slot_end) ? '0 : cnt + 1'b1;
      sel_nx   = !enable ? 2'd0 : mux_sel + {1'b0, slot_end};
      state_nx = (enable && cnt_nx >= BLK) ? ON : BLANK;
      disp_nx  = !wrap ? disp_value : load ? value_in : pend_valid ? pend : disp_value;
      cdot_nx  = !wrap ? cdot : load ? dot_in : pend_valid ? pend_dot : cdot;
      lz_mask  = {4{lzb_en}} & {disp_nx[15:12] == '0, disp_nx[15:8] == '0,
                                disp_nx[15:4] == '0, 1'b0};
      lit      = state_nx == ON && !lz_mask[sel_nx];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         mux_sel    <= 2'd0;
         disp_value <= '0;
         cdot       <= '0;
         anode_n    <= 4'hF;
         dot_n      <= 1'b1;
         frame_done <= 1'b0;
         pend       <= '0;
         pend_dot   <= '0;
         pend_valid <= 1'b0;
      end else begin
         cnt        <= cnt_nx;
         mux_sel    <= sel_nx;
         disp_value <= disp_nx;
         cdot       <= cdot_nx;
         anode_n    <= lit ? ~(4'b0001 << sel_nx) : 4'hF;
         dot_n      <= ~(lit & cdot_nx[sel_nx]);
         frame_done <= cnt_nx == LAST && sel_nx == 2'd3;
         if (load && !wrap) begin
            pend       <= value_in;
            pend_dot   <= dot_in;
            pend_valid <= 1'b1;
         end else if (wrap) begin
            pend_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb_seg7_scan_controller: directed table-driven bench with PRESCALE=8, BLANK_CYCLES=2.
module tb_seg7_scan_controller;
   logic        clk = 0, reset = 1, enable = 1, load = 0, lzb_en = 0;
   logic [15:0] value_in = 0;
   logic [3:0]  dot_in = 0;
   logic [1:0]  mux_sel;
   logic [15:0] disp_value;
   logic [3:0]  anode_n;
   logic        dot_n, frame_done;
   int          c = 0, checks = 0, errors = 0;

   typedef struct {
      int          c;
      logic [3:0]  an;
      logic [1:0]  sel;
      logic        fd;
      logic [15:0] disp;
   } vec_t;
   vec_t tbl[$];

   seg7_scan_controller #(.PRESCALE(8), .BLANK_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .load(load), .value_in(value_in),
      .dot_in(dot_in), .lzb_en(lzb_en), .mux_sel(mux_sel), .disp_value(disp_value),
      .anode_n(anode_n), .dot_n(dot_n), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      c++;
   endtask

   task automatic go_to(input int n);
      while (c < n) tick();
   endtask

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, got, exp);
      end
   endtask

   task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
      load = 1;
      value_in = v;
      dot_in = d;
      tick();
      load = 0;
   endtask

   function automatic logic [3:0] exp_an(input int cy, input bit only0);
      int cn = cy % 8;
      int sl = (cy / 8) % 4;
      logic [3:0] one = 4'b0001;
      if (cn < 2 || (only0 && sl != 0)) return 4'hF;
      return ~(one << sl);
   endfunction

   initial begin
      tbl.push_back('{1,  4'hF, 2'd0, 1'b0, 16'h0000});
      tbl.push_back('{2,  4'hE, 2'd0, 1'b0, 16'h0000});
      tbl.push_back('{7,  4'hE, 2'd0, 1'b0, 16'h0000});
      tbl.push_back('{8,  4'hF, 2'd1, 1'b0, 16'h0000});
      tbl.push_back('{9,  4'hF, 2'd1, 1'b0, 16'h0000});
      tbl.push_back('{10, 4'hD, 2'd1, 1'b0, 16'h0000});
      tbl.push_back('{17, 4'hF, 2'd2, 1'b0, 16'h0000});
      tbl.push_back('{18, 4'hB, 2'd2, 1'b0, 16'h0000});
      tbl.push_back('{26, 4'h7, 2'd3, 1'b0, 16'h0000});
      tbl.push_back('{31, 4'h7, 2'd3, 1'b1, 16'h0000});
      tbl.push_back('{32, 4'hF, 2'd0, 1'b0, 16'h1234});
      tbl.push_back('{34, 4'hE, 2'd0, 1'b0, 16'h1234});
      tbl.push_back('{62, 4'h7, 2'd3, 1'b0, 16'h1234});
      tbl.push_back('{63, 4'h7, 2'd3, 1'b1, 16'h1234});
      tbl.push_back('{64, 4'hF, 2'd0, 1'b0, 16'h1234});

      repeat (2) @(posedge clk);
      #1;
      chk("reset_anode", 16'(anode_n), 16'hF);
      chk("reset_disp", disp_value, 16'h0);
      reset = 0;
      c = 0;
      chk("rel_sel", 16'(mux_sel), 16'h0);
      chk("rel_fd", 16'(frame_done), 16'h0);
      pulse_load(16'h1234, 4'b0000);
      foreach (tbl[i]) begin
         go_to(tbl[i].c);
         chk("tbl_anode", 16'(anode_n), 16'(tbl[i].an));
         chk("tbl_sel", 16'(mux_sel), 16'(tbl[i].sel));
         chk("tbl_fd", 16'(frame_done), 16'(tbl[i].fd));
         chk("tbl_disp", disp_value, tbl[i].disp);
         chk("tbl_dot", 16'(dot_n), 16'h1);
      end

      go_to(70);
      pulse_load(16'hAAAA, 4'b0000);
      go_to(75);
      pulse_load(16'h5555, 4'b0000);
      go_to(80);
      chk("multi_hold_mid", disp_value, 16'h1234);
      go_to(95);
      chk("multi_hold_fd", disp_value, 16'h1234);
      tick();
      chk("multi_last_wins", disp_value, 16'h5555);

      go_to(127);
      chk("bypass_fd", 16'(frame_done), 16'h1);
      pulse_load(16'h00F0, 4'b0000);
      chk("bypass_disp", disp_value, 16'h00F0);

      go_to(140);
      pulse_load(16'h0007, 4'b1000);
      go_to(159);
      lzb_en = 1;
      while (c < 191) begin
         tick();
         chk("lzb_anode", 16'(anode_n), 16'(exp_an(c, 1'b1)));
         chk("lzb_dot", 16'(dot_n), 16'h1);
         if (c == 170) begin
            load = 1;
            value_in = 16'h1234;
            dot_in = 4'b0010;
         end else begin
            load = 0;
         end
      end
      chk("lzb_disp", disp_value, 16'h0007);
      lzb_en = 0;
      while (c < 223) begin
         tick();
         chk("dot_anode", 16'(anode_n), 16'(exp_an(c, 1'b0)));
         chk("dot_n", 16'(dot_n), 16'((c % 8 >= 2 && (c / 8) % 4 == 1) ? 0 : 1));
      end

      go_to(243);
      chk("pre_dis_anode", 16'(anode_n), 16'hB);
      enable = 0;
      repeat (5) begin
         tick();
         chk("dis_anode", 16'(anode_n), 16'hF);
         chk("dis_sel", 16'(mux_sel), 16'h0);
         chk("dis_fd", 16'(frame_done), 16'h0);
      end
      enable = 1;
      tick();
      chk("reen_blank", 16'(anode_n), 16'hF);
      tick();
      chk("reen_on", 16'(anode_n), 16'hE);
      chk("reen_sel", 16'(mux_sel), 16'h0);
      chk("reen_disp", disp_value, 16'h1234);

      pulse_load(16'hBEEF, 4'hF);
      go_to(253);
      #2;
      reset = 1;
      #1;
      chk("arst_anode", 16'(anode_n), 16'hF);
      chk("arst_disp", disp_value, 16'h0);
      chk("arst_dot", 16'(dot_n), 16'h1);
      @(posedge clk);
      #1;
      reset = 0;
      c = 0;
      go_to(2);
      chk("post_rst_on", 16'(anode_n), 16'hE);
      go_to(31);
      chk("post_rst_fd", 16'(frame_done), 16'h1);
      tick();
      chk("pend_discarded", disp_value, 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
